mem_wr_downsizer: RTL and testbench
===================================

# mem_wr_downsizer

Write-path width converter for the SDRAM controller. It sits between the Wishbone-side write-data stream (WB_DW data, byte mask, byte address) and the SDRAM-side write port (MEM_DW). Each accepted wide word is serialized into SCALE = WB_DW/MEM_DW narrow beats, each with its own mask and byte address. It is the write-direction counterpart of the read upsizer.

## Interface
- WB_DW, 32: wide (Wishbone) data width; multiple of MEM_DW.
- MEM_DW, 16: narrow (memory) data width; multiple of 8.
- AW, 32: byte-address width on both sides.
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- s_adr_i  in  AW  byte address of the wide word; low log2(WB_DW/8) bits are ignored.
- s_data_i  in  WB_DW  write data.
- s_mask_i  in  WB_DW/8  byte enables, 1 = write byte.
- s_valid_i  in  1  input word valid.
- s_ready_o  out  1  input word accepted when s_valid_i & s_ready_o.
- m_adr_o  out  AW  byte address of the current beat.
- m_data_o  out  MEM_DW  beat data.
- m_mask_o  out  MEM_DW/8  beat byte enables.
- m_last_o  out  1  final beat of the current word.
- m_valid_o  out  1  beat valid.
- m_ready_i  in  1  beat accepted when m_valid_o & m_ready_i.

## Operation
- SCALE = WB_DW/MEM_DW. It must be a power of 2 and at least 2. Beat index width is log2(SCALE).
- Little-endian lane order. Beat k carries s_data_i[k*MEM_DW +: MEM_DW] and s_mask_i[k*MEM_DW/8 +: MEM_DW/8].
- Beat k address = {s_adr_i[AW-1:log2(WB_DW/8)], zeros} + k*MEM_DW/8.
- States:
  - EMPTY (m_valid_o=0).
  - BUSY(k) (m_valid_o=1, presenting beat k).
- s_ready_o = !m_valid_o | (m_ready_i & m_last_o). This is combinational from m_ready_i and must not create a combinational loop.
- On accept: data, mask and base address are registered. The block enters BUSY(first beat).
- In BUSY(k), when m_ready_i = 1:
  - If the beat is not last, advance to the next beat.
  - If it is last and a new word is accepted in the same cycle, load that word.
  - Otherwise go to EMPTY.
- The held word and all m_* outputs stay stable while m_valid_o & !m_ready_i.
- Reset values: m_valid_o=0, m_last_o=0, m_data_o=0, m_mask_o=0, m_adr_o=0, internal index=0. Hence s_ready_o=1.
- Reset mid-word: the buffered word is discarded. No residual beats appear after release.

## Timing
- Latency: word accepted at edge N, beat 0 valid after edge N (registered outputs).
- Throughput: 1 beat/cycle with m_ready_i held high. Back-to-back words have no bubble, because the next word is accepted on the last-beat cycle.
- Input accept rate is at most 1 word per SCALE cycles (no-skip build).
- m_last_o is high only when m_valid_o is high.

## Configuration
- MEM_WR_DOWNSIZER_SKIP_EN undefined:
  - All SCALE beats are always emitted, including beats whose mask is all zero.
  - m_last_o is set on beat SCALE-1.
- MEM_WR_DOWNSIZER_SKIP_EN defined:
  - Beats with an all-zero mask are not emitted. The next emitted beat is the lowest remaining lane with a nonzero mask.
  - m_last_o is set on the highest nonzero-mask lane.
  - A word with s_mask_i = 0 is accepted (s_ready_o rule unchanged) and dropped. No beat is emitted and the block stays EMPTY or proceeds to the following word.

## Structure
- Shared package sdram_ctrl_pkg holds:
  - the SCALE and beat-index-width derivation function;
  - the lane-select helper (find lowest set lane at or above k), used by the skip build.
- One sub-module, stream_downsizer: a generic data+mask serializer with its valid/ready/last handshake, mirroring stream_upsizer.
- mem_wr_downsizer wraps stream_downsizer and adds address base/offset generation.

## Test plan
All scenarios use WB_DW=32, MEM_DW=16.
- Word adr 0x100, data 0xAABBCCDD, mask 0xF, m_ready_i=1 -> (0x100, 0xCCDD, 2'b11, last=0) then (0x102, 0xAABB, 2'b11, last=1) on consecutive cycles; s_ready_o=0 during beat 0.
- Three back-to-back words at 0x0/0x4/0x8, m_ready_i=1 -> six contiguous beats at addresses 0x0,0x2,0x4,0x6,0x8,0xA with no gap; s_ready_o=1 only on the last-beat cycles.
- m_ready_i low for 3 cycles during beat 1 of 0x12345678 -> m_data_o=0x1234, m_adr_o and m_mask_o held for 3 cycles; s_ready_o=0 throughout.
- Mask 0x3, data 0x11112222 -> without macro: beats (0x2222, 2'b11) and (0x1111, 2'b00, last); with MEM_WR_DOWNSIZER_SKIP_EN: the single beat (0x2222, 2'b11, last=1).
- With MEM_WR_DOWNSIZER_SKIP_EN: mask 0x0 then mask 0xC at adr 0x20 -> the first word is consumed with no beat; only the beat (0x22, upper half, 2'b11, last=1) follows.
- rst_n pulled low while beat 0 is valid -> m_valid_o=0 immediately (asynchronous); after release, s_ready_o=1 and no beat appears until a new word is sent.

Source files
------------

// File: rtl/sdram_ctrl_pkg.sv
// Shared SDRAM controller helpers: width-ratio derivation and lane search
// used by the stream up/downsizers.
package sdram_ctrl_pkg;

  localparam int MAX_LANES = 32;

  typedef enum logic {
    EMPTY = 1'b0,
    BUSY  = 1'b1
  } dsz_state_e;

  function automatic int calc_scale(input int wide_dw, input int narrow_dw);
    return wide_dw / narrow_dw;
  endfunction

  function automatic int calc_idx_w(input int scale);
    return (scale > 1) ? $clog2(scale) : 1;
  endfunction

  // Lowest lane index >= start whose bit is set, or -1 when none remain.
  function automatic int lowest_lane(input logic [MAX_LANES-1:0] lanes,
                                     input int start, input int scale);
    int found;
    found = -1;
    for (int k = MAX_LANES - 1; k >= 0; k--) begin
      if (k < scale && k >= start && lanes[k]) found = k;
    end
    return found;
  endfunction

endpackage

// File: rtl/stream_downsizer.sv
// Generic data+mask serializer: one wide word in, SCALE narrow beats out.
// MEM_WR_DOWNSIZER_SKIP_EN drops beats whose byte mask is all zero.
//
// state | meaning
// EMPTY | no word held, m_valid=0, input always ready
// BUSY  | presenting beat idx of the held word, m_valid=1
module stream_downsizer
  import sdram_ctrl_pkg::*;
#(
  parameter  int IN_DW  = 32,
  parameter  int OUT_DW = 16,
  localparam int SCALE  = calc_scale(IN_DW, OUT_DW),
  localparam int IW     = calc_idx_w(SCALE),
  localparam int IN_MW  = IN_DW / 8,
  localparam int OUT_MW = OUT_DW / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IN_DW-1:0]  s_data,
  input  logic [IN_MW-1:0]  s_mask,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              s_load,
  output logic [OUT_DW-1:0] m_data,
  output logic [OUT_MW-1:0] m_mask,
  output logic              m_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [IW-1:0]     m_idx
);

  dsz_state_e        state;
  logic [IN_DW-1:0]  data_q;
  logic [IN_MW-1:0]  mask_q;
  logic [IW-1:0]     next_idx;
  logic              next_last;

  // The last beat frees the buffer, so a new word can load in the same cycle.
  assign s_ready = !m_valid | (m_ready & m_last);
  assign s_load  = s_valid & s_ready;

  assign m_data = data_q[m_idx*OUT_DW +: OUT_DW];
  assign m_mask = mask_q[m_idx*OUT_MW +: OUT_MW];

`ifdef MEM_WR_DOWNSIZER_SKIP_EN
  logic [SCALE-1:0] lane_nz_in;
  logic [SCALE-1:0] lane_nz_q;
  logic [IW-1:0]    first_idx;
  logic             first_last;
  int               lo_in;
  int               lo_nxt;

  always_comb begin
    for (int k = 0; k < SCALE; k++) begin
      lane_nz_in[k] = |s_mask[k*OUT_MW +: OUT_MW];
      lane_nz_q[k]  = |mask_q[k*OUT_MW +: OUT_MW];
    end
  end

  always_comb begin
    lo_in      = lowest_lane(MAX_LANES'(lane_nz_in), 0, SCALE);
    lo_nxt     = lowest_lane(MAX_LANES'(lane_nz_q), int'(m_idx) + 1, SCALE);
    first_idx  = (lo_in < 0) ? '0 : IW'(lo_in);
    first_last = lowest_lane(MAX_LANES'(lane_nz_in), lo_in + 1, SCALE) < 0;
    next_idx   = (lo_nxt < 0) ? m_idx : IW'(lo_nxt);
    next_last  = lowest_lane(MAX_LANES'(lane_nz_q), lo_nxt + 1, SCALE) < 0;
  end
`else
  always_comb begin
    next_idx  = m_idx + IW'(1);
    next_last = (next_idx == IW'(SCALE - 1));
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= EMPTY;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      m_idx   <= '0;
      data_q  <= '0;
      mask_q  <= '0;
    end else if (s_load) begin
      data_q <= s_data;
      mask_q <= s_mask;
`ifdef MEM_WR_DOWNSIZER_SKIP_EN
      if (|s_mask) begin
        state   <= BUSY;
        m_valid <= 1'b1;
        m_idx   <= first_idx;
        m_last  <= first_last;
      end else begin
        state   <= EMPTY;
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end
`else
      state   <= BUSY;
      m_valid <= 1'b1;
      m_idx   <= '0;
      m_last  <= 1'b0;
`endif
    end else if (state == BUSY && m_ready) begin
      if (!m_last) begin
        m_idx  <= next_idx;
        m_last <= next_last;
      end else begin
        state   <= EMPTY;
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mem_wr_downsizer.sv
// SDRAM write-path width converter: serializes Wishbone-width words into
// memory-width beats with per-beat address. Optional MEM_WR_DOWNSIZER_SKIP_EN.
module mem_wr_downsizer
  import sdram_ctrl_pkg::*;
#(
  parameter int WB_DW  = 32,
  parameter int MEM_DW = 16,
  parameter int AW     = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [AW-1:0]       s_adr_i,
  input  logic [WB_DW-1:0]    s_data_i,
  input  logic [WB_DW/8-1:0]  s_mask_i,
  input  logic                s_valid_i,
  output logic                s_ready_o,
  output logic [AW-1:0]       m_adr_o,
  output logic [MEM_DW-1:0]   m_data_o,
  output logic [MEM_DW/8-1:0] m_mask_o,
  output logic                m_last_o,
  output logic                m_valid_o,
  input  logic                m_ready_i
);

  localparam int SCALE = calc_scale(WB_DW, MEM_DW);
  localparam int IW    = calc_idx_w(SCALE);

  logic          s_load;
  logic [IW-1:0] m_idx;
  logic [AW-1:0] base_q;

  stream_downsizer #(
    .IN_DW  (WB_DW),
    .OUT_DW (MEM_DW)
  ) u_sdz (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_data  (s_data_i),
    .s_mask  (s_mask_i),
    .s_valid (s_valid_i),
    .s_ready (s_ready_o),
    .s_load  (s_load),
    .m_data  (m_data_o),
    .m_mask  (m_mask_o),
    .m_last  (m_last_o),
    .m_valid (m_valid_o),
    .m_ready (m_ready_i),
    .m_idx   (m_idx)
  );

  // Base is word-aligned; sub-word address bits from the bus are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) base_q <= '0;
    else if (s_load) base_q <= s_adr_i & ~AW'(WB_DW / 8 - 1);
  end

  assign m_adr_o = base_q + AW'(m_idx) * AW'(MEM_DW / 8);

endmodule

// File: tb/tb_mem_wr_downsizer.sv
// Scoreboard bench for mem_wr_downsizer (WB_DW=32, MEM_DW=16).
module tb_mem_wr_downsizer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] s_adr_i = '0;
  logic [31:0] s_data_i = '0;
  logic [3:0]  s_mask_i = '0;
  logic        s_valid_i = 1'b0;
  logic        s_ready_o;
  logic [31:0] m_adr_o;
  logic [15:0] m_data_o;
  logic [1:0]  m_mask_o;
  logic        m_last_o;
  logic        m_valid_o;
  logic        m_ready_i = 1'b1;

  typedef logic [50:0] beat_t;
  beat_t exp_q[$];
  int n_pass = 0;
  int n_tot  = 0;

  mem_wr_downsizer #(.WB_DW(32), .MEM_DW(16), .AW(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_adr_i   (s_adr_i),
    .s_data_i  (s_data_i),
    .s_mask_i  (s_mask_i),
    .s_valid_i (s_valid_i),
    .s_ready_o (s_ready_o),
    .m_adr_o   (m_adr_o),
    .m_data_o  (m_data_o),
    .m_mask_o  (m_mask_o),
    .m_last_o  (m_last_o),
    .m_valid_o (m_valid_o),
    .m_ready_i (m_ready_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic exp_beat(input logic [31:0] a, input logic [15:0] d, input logic [1:0] m,
                          input logic l);
    exp_q.push_back({a, d, m, l});
  endtask

  // Monitor: every accepted beat must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && m_valid_o && m_ready_i) begin
      if (exp_q.size() == 0) begin
        n_tot++;
        $display("FAIL unexpected_beat: got adr=%0h data=%0h mask=%0b last=%0b, none expected",
                 m_adr_o, m_data_o, m_mask_o, m_last_o);
      end else begin
        chk("beat{adr,data,mask,last}", 64'({m_adr_o, m_data_o, m_mask_o, m_last_o}),
            64'(exp_q.pop_front()));
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    bit acc;
    s_adr_i = a; s_data_i = d; s_mask_i = m; s_valid_i = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      acc = s_ready_o;
      @(posedge clk);
      #1;
    end
    s_valid_i = 1'b0;
    if (!acc) begin
      n_tot++;
      $display("FAIL send_timeout: word at %0h not accepted within 20 cycles", a);
    end
  endtask

  initial begin
    // reset state
    #2;
    chk("rst_m_valid", m_valid_o, 0);
    chk("rst_m_last", m_last_o, 0);
    chk("rst_m_data", m_data_o, 0);
    chk("rst_m_mask", m_mask_o, 0);
    chk("rst_m_adr", m_adr_o, 0);
    chk("rst_s_ready", s_ready_o, 1);
    #20 rst_n = 1'b1;
    @(posedge clk); #1;

    // single word
    exp_beat(32'h100, 16'hCCDD, 2'b11, 1'b0);
    exp_beat(32'h102, 16'hAABB, 2'b11, 1'b1);
    send(32'h100, 32'hAABBCCDD, 4'hF);
    @(negedge clk);
    chk("t1_s_ready_beat0", s_ready_o, 0);
    chk("t1_last_beat0", m_last_o, 0);
    @(negedge clk);
    chk("t1_s_ready_beat1", s_ready_o, 1);
    @(negedge clk);
    chk("t1_idle_after", m_valid_o, 0);
    @(posedge clk); #1;

    // three back-to-back words
    for (int i = 0; i < 6; i++)
      exp_beat(32'(2 * i), 16'(16'h1000 + i), 2'b11, i[0]);
    send(32'h0, 32'h1001_1000, 4'hF);
    fork
      begin
        send(32'h4, 32'h1003_1002, 4'hF);
        send(32'h8, 32'h1005_1004, 4'hF);
      end
      begin
        for (int i = 0; i < 6; i++) begin
          @(negedge clk);
          chk($sformatf("t2_valid_cyc%0d", i), m_valid_o, 1);
          chk($sformatf("t2_s_ready_cyc%0d", i), s_ready_o, 64'(i % 2));
        end
      end
    join
    @(negedge clk);
    chk("t2_idle_after", m_valid_o, 0);
    @(posedge clk); #1;

    // stall during beat 1
    exp_beat(32'h40, 16'h5678, 2'b11, 1'b0);
    exp_beat(32'h42, 16'h1234, 2'b11, 1'b1);
    send(32'h40, 32'h12345678, 4'hF);
    @(posedge clk); #1;
    m_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("t3_hold_data%0d", i), m_data_o, 16'h1234);
      chk($sformatf("t3_hold_adr%0d", i), m_adr_o, 32'h42);
      chk($sformatf("t3_hold_mask%0d", i), m_mask_o, 2'b11);
      chk($sformatf("t3_hold_s_ready%0d", i), s_ready_o, 0);
      @(posedge clk); #1;
    end
    m_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // partial mask
`ifdef MEM_WR_DOWNSIZER_SKIP_EN
    exp_beat(32'h60, 16'h2222, 2'b11, 1'b1);
`else
    exp_beat(32'h60, 16'h2222, 2'b11, 1'b0);
    exp_beat(32'h62, 16'h1111, 2'b00, 1'b1);
`endif
    send(32'h60, 32'h11112222, 4'h3);
    repeat (4) @(posedge clk);
    #1;

    // all-zero mask word followed by upper-half word
`ifdef MEM_WR_DOWNSIZER_SKIP_EN
    exp_beat(32'h22, 16'hBEEF, 2'b11, 1'b1);
`else
    exp_beat(32'h10, 16'hDEAD, 2'b00, 1'b0);
    exp_beat(32'h12, 16'hC0DE, 2'b00, 1'b1);
    exp_beat(32'h20, 16'h0000, 2'b00, 1'b0);
    exp_beat(32'h22, 16'hBEEF, 2'b11, 1'b1);
`endif
    send(32'h10, 32'hC0DEDEAD, 4'h0);
    send(32'h20, 32'hBEEF0000, 4'hC);
    repeat (6) @(posedge clk);
    #1;

    // reset while beat 0 is valid: beats of this word must never appear
    send(32'h80, 32'h55667788, 4'hF);
    m_ready_i = 1'b0;
    chk("t6_valid_before_rst", m_valid_o, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", m_valid_o, 0);
    chk("t6_rst_last", m_last_o, 0);
    chk("t6_rst_s_ready", s_ready_o, 1);
    @(negedge clk); #2 rst_n = 1'b1;
    m_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("t6_no_residual%0d", i), m_valid_o, 0);
    end
    chk("t6_s_ready_after", s_ready_o, 1);

    // scoreboard drain
    for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(posedge clk);
    chk("scoreboard_drain", 64'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
